// File: rtl/fb_pkg.sv
// Framebuffer geometry and the rectangle-fill state type, shared by the write
// arbiter, its cursor walker and the interface that bundles the write port.
package fb_pkg;
    localparam int FB_WIDTH  = 160;
    localparam int FB_HEIGHT = 120;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_AW     = 15;
    localparam int FB_DW     = 16;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DONE
    } fill_state_t;
endpackage

// File: rtl/fb_write_arbiter_if.sv
// MCU store port, fill command/status and framebuffer write port in one bundle.
// master = MCU/bus-decode side, slave = the arbiter that owns the framebuffer port.
interface fb_write_arbiter_if;
    import fb_pkg::*;

    logic [FB_AW-1:0] CPU_WA;
    logic [FB_DW-1:0] CPU_WD;
    logic             CPU_WE;
    logic             CPU_WAIT;
    logic             FILL_START;
    logic             FILL_ABORT;
    logic [7:0]       FILL_X0;
    logic [7:0]       FILL_X1;
    logic [6:0]       FILL_Y0;
    logic [6:0]       FILL_Y1;
    logic [FB_DW-1:0] FILL_COLOR;
    logic             FILL_BUSY;
    logic             FILL_DONE;
    logic             FILL_ERR;
    logic [FB_AW-1:0] FB_WA;
    logic [FB_DW-1:0] FB_WD;
    logic             FB_WE;

    modport master (
        output CPU_WA, CPU_WD, CPU_WE, FILL_START, FILL_ABORT,
               FILL_X0, FILL_X1, FILL_Y0, FILL_Y1, FILL_COLOR,
        input  CPU_WAIT, FILL_BUSY, FILL_DONE, FILL_ERR, FB_WA, FB_WD, FB_WE
    );

    modport slave (
        input  CPU_WA, CPU_WD, CPU_WE, FILL_START, FILL_ABORT,
               FILL_X0, FILL_X1, FILL_Y0, FILL_Y1, FILL_COLOR,
        output CPU_WAIT, FILL_BUSY, FILL_DONE, FILL_ERR, FB_WA, FB_WD, FB_WE
    );
endinterface

// File: rtl/fb_rect_walker.sv
// Raster cursor over an inclusive rectangle: addr/last are combinational from the cursor,
// which advances one pixel per step; no backpressure of its own (step is the grant).
module fb_rect_walker
    import fb_pkg::*;
#(
    parameter int WIDTH = FB_WIDTH
) (
    input  logic             CLK_50MHz,
    input  logic             RESET,
    input  logic             load,
    input  logic             step,
    input  logic [7:0]       x0,
    input  logic [7:0]       x1,
    input  logic [6:0]       y0,
    input  logic [6:0]       y1,
    output logic [FB_AW-1:0] addr,
    output logic             last
);
    localparam logic [FB_AW-1:0] ROW_STEP = FB_AW'(WIDTH);

    logic [7:0]       x_q, x0_q, x1_q;
    logic [6:0]       y_q, y1_q;
    logic [FB_AW-1:0] rowbase_q;

    // The multiply only happens once per command; per-pixel rows advance by addition.
    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            x_q       <= '0;
            x0_q      <= '0;
            x1_q      <= '0;
            y_q       <= '0;
            y1_q      <= '0;
            rowbase_q <= '0;
        end else if (load) begin
            x_q       <= x0;
            x0_q      <= x0;
            x1_q      <= x1;
            y_q       <= y0;
            y1_q      <= y1;
            rowbase_q <= FB_AW'(y0) * ROW_STEP;
        end else if (step) begin
            if (x_q == x1_q) begin
                x_q       <= x0_q;
                y_q       <= y_q + 7'd1;
                rowbase_q <= rowbase_q + ROW_STEP;
            end else begin
                x_q <= x_q + 8'd1;
            end
        end
    end

    assign addr = rowbase_q + FB_AW'(x_q);
    assign last = (x_q == x1_q) && (y_q == y1_q);
endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between MCU stores and the rectangle-fill engine; FB_* lag the grant by 1 cycle.
// CPU wins each cycle unless the fill has been denied MAX_STALL times in a row; CPU_WAIT is raised only then.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int WIDTH     = FB_WIDTH,
    parameter int HEIGHT    = FB_HEIGHT,
    parameter int MAX_STALL = 8
) (
    input  logic               CLK_50MHz,
    input  logic               RESET,
    fb_write_arbiter_if.slave  bus
);
    localparam logic [7:0] X_LIMIT     = 8'(WIDTH);
    localparam logic [6:0] Y_LIMIT     = 7'(HEIGHT);
    localparam logic [7:0] STALL_LIMIT = 8'(MAX_STALL);

    fill_state_t      state_q, state_d;
    logic [7:0]       stall_q, stall_d;
    logic [FB_DW-1:0] color_q;
    logic             err_q, err_d;
    logic             cmd_valid, load, fill_grant, cpu_grant;
    logic [FB_AW-1:0] fill_addr;
    logic             fill_last;

    assign cmd_valid = (bus.FILL_X0 <= bus.FILL_X1) && (bus.FILL_Y0 <= bus.FILL_Y1) &&
                       (bus.FILL_X1 < X_LIMIT) && (bus.FILL_Y1 < Y_LIMIT);

    always_comb begin
        state_d    = state_q;
        stall_d    = '0;
        load       = 1'b0;
        fill_grant = 1'b0;
        cpu_grant  = bus.CPU_WE;
        err_d      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.FILL_START) begin
                    if (cmd_valid) begin
                        load    = 1'b1;
                        state_d = FILL;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            FILL: begin
                if (bus.CPU_WE && (stall_q < STALL_LIMIT)) begin
                    stall_d = stall_q + 8'd1;
                end else begin
                    fill_grant = 1'b1;
                    cpu_grant  = 1'b0;
                end
                // Finishing the last pixel outranks a simultaneous abort.
                if (fill_grant && fill_last) begin
                    state_d = DONE;
                end else if (bus.FILL_ABORT) begin
                    state_d = IDLE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50MHz or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            stall_q   <= '0;
            color_q   <= '0;
            err_q     <= 1'b0;
            bus.FB_WA <= '0;
            bus.FB_WD <= '0;
            bus.FB_WE <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            if (load) begin
                color_q <= bus.FILL_COLOR;
            end
            if (fill_grant) begin
                bus.FB_WA <= fill_addr;
                bus.FB_WD <= color_q;
                bus.FB_WE <= 1'b1;
            end else if (cpu_grant) begin
                bus.FB_WA <= bus.CPU_WA;
                bus.FB_WD <= bus.CPU_WD;
                bus.FB_WE <= 1'b1;
            end else begin
                bus.FB_WE <= 1'b0;
            end
        end
    end

    fb_rect_walker #(.WIDTH(WIDTH)) u_walker (
        .CLK_50MHz (CLK_50MHz),
        .RESET     (RESET),
        .load      (load),
        .step      (fill_grant),
        .x0        (bus.FILL_X0),
        .x1        (bus.FILL_X1),
        .y0        (bus.FILL_Y0),
        .y1        (bus.FILL_Y1),
        .addr      (fill_addr),
        .last      (fill_last)
    );

    assign bus.CPU_WAIT  = fill_grant && bus.CPU_WE;
    assign bus.FILL_BUSY = (state_q == FILL);
    assign bus.FILL_DONE = (state_q == DONE);
    assign bus.FILL_ERR  = err_q;
endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed + randomized bench for fb_write_arbiter; expected writes come from a
// raster-order rectangle model and a queue of MCU stores accepted while CPU_WAIT was low.
module tb_fb_write_arbiter;
    import fb_pkg::*;

    localparam int MAX_STALL = 8;

    typedef struct {
        logic [14:0] a;
        logic [15:0] d;
        int          c;
    } wr_t;

    logic CLK_50MHz = 1'b0;
    logic RESET;

    fb_write_arbiter_if bus();

    fb_write_arbiter #(
        .WIDTH     (FB_WIDTH),
        .HEIGHT    (FB_HEIGHT),
        .MAX_STALL (MAX_STALL)
    ) dut (
        .CLK_50MHz (CLK_50MHz),
        .RESET     (RESET),
        .bus       (bus)
    );

    always #5 CLK_50MHz = ~CLK_50MHz;

    int          cyc = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          err_cnt = 0;
    int          total = 0;
    int          bad = 0;
    int          wait_cnt = 0;
    int          step_cyc = 0;
    bit          pend = 1'b0;
    logic [15:0] cur_color = 16'h0;
    wr_t         wr_q[$];
    wr_t         exp_cpu[$];

    always @(posedge CLK_50MHz) cyc <= cyc + 1;

    always @(negedge CLK_50MHz) begin
        if (!RESET) begin
            if (bus.FB_WE) wr_q.push_back('{bus.FB_WA, bus.FB_WD, cyc});
            if (bus.FILL_DONE) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (bus.FILL_ERR) err_cnt <= err_cnt + 1;
        end
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cmd(input int x0, input int x1, input int y0, input int y1, input logic [15:0] col);
        bus.FILL_X0    = 8'(x0);
        bus.FILL_X1    = 8'(x1);
        bus.FILL_Y0    = 7'(y0);
        bus.FILL_Y1    = 7'(y1);
        bus.FILL_COLOR = col;
    endtask

    // mode 0: MCU idle, 1: random requests, 2: request every cycle. Held while CPU_WAIT.
    task automatic drive_cpu(input int mode);
        logic [15:0] d;
        if (!pend) begin
            if (mode == 2 || (mode == 1 && $urandom_range(0, 1) == 1)) begin
                d = 16'($urandom);
                if (d == cur_color) d = ~d;
                bus.CPU_WA = 15'($urandom_range(0, FB_PIXELS - 1));
                bus.CPU_WD = d;
                bus.CPU_WE = 1'b1;
            end else begin
                bus.CPU_WE = 1'b0;
            end
        end
    endtask

    task automatic step(input int mode, input bit start, input bit abort);
        @(negedge CLK_50MHz);
        step_cyc       = cyc;
        bus.FILL_START = start;
        bus.FILL_ABORT = abort;
        drive_cpu(mode);
        #1;
        if (bus.CPU_WE && !bus.CPU_WAIT) begin
            exp_cpu.push_back('{bus.CPU_WA, bus.CPU_WD, cyc + 1});
            pend = 1'b0;
        end else begin
            pend = bus.CPU_WE;
        end
        if (bus.CPU_WAIT) wait_cnt++;
    endtask

    task automatic check_fill(input string tag, input int base, input int x0, input int x1,
                              input int y0, input int y1, input logic [15:0] col,
                              input int sc, input int mode, input int d0, input int w0);
        int  exp_a[$];
        wr_t cpu_seen[$];
        int  k = 0, mism = 0, cmism = 0, run = 0, maxrun = 0, badrun = 0, last_fill = -1;
        for (int y = y0; y <= y1; y++)
            for (int x = x0; x <= x1; x++)
                exp_a.push_back(y * FB_WIDTH + x);
        for (int i = base; i < wr_q.size(); i++) begin
            if (wr_q[i].d == col) begin
                if (k >= exp_a.size() || int'(wr_q[i].a) != exp_a[k]) mism++;
                k++;
                last_fill = wr_q[i].c;
                if (run > maxrun) maxrun = run;
                if (mode == 2 && run != MAX_STALL) badrun++;
                run = 0;
            end else begin
                cpu_seen.push_back(wr_q[i]);
                if (wr_q[i].c >= sc + 2) run++;
            end
        end
        for (int j = 0; j < cpu_seen.size() && j < exp_cpu.size(); j++)
            if (cpu_seen[j].a !== exp_cpu[j].a || cpu_seen[j].d !== exp_cpu[j].d ||
                cpu_seen[j].c != exp_cpu[j].c) cmism++;
        chk({tag, "_fill_cnt"}, k, exp_a.size());
        chk({tag, "_fill_addr"}, mism, 0);
        chk({tag, "_done_cnt"}, done_cnt - d0, 1);
        chk({tag, "_done_with_last"}, done_cyc, last_fill);
        chk({tag, "_stall_bound"}, maxrun <= MAX_STALL, 1);
        chk({tag, "_cpu_cnt"}, cpu_seen.size(), exp_cpu.size());
        chk({tag, "_cpu_data"}, cmism, 0);
        if (mode == 0) chk({tag, "_done_lat"}, done_cyc - sc, exp_a.size() + 1);
        if (mode == 2) begin
            chk({tag, "_runs_of_8"}, badrun, 0);
            chk({tag, "_wait_cnt"}, wait_cnt - w0, exp_a.size());
        end
    endtask

    task automatic run_fill(input string tag, input int x0, input int x1, input int y0,
                            input int y1, input logic [15:0] col, input int mode);
        int base, d0, w0, sc, n, budget;
        base   = wr_q.size();
        d0     = done_cnt;
        w0     = wait_cnt;
        budget = 9 * (x1 - x0 + 1) * (y1 - y0 + 1) + 20;
        exp_cpu.delete();
        cur_color = col;
        set_cmd(x0, x1, y0, y1, col);
        step(mode, 1'b1, 1'b0);
        sc = step_cyc;
        n  = 0;
        while (done_cnt == d0 && n < budget) begin
            step(mode, 1'b0, 1'b0);
            n++;
        end
        repeat (3) step(0, 1'b0, 1'b0);
        chk({tag, "_we_idle"}, bus.FB_WE, 0);
        chk({tag, "_busy_idle"}, bus.FILL_BUSY, 0);
        check_fill(tag, base, x0, x1, y0, y1, col, sc, mode, d0, w0);
    endtask

    task automatic bad_cmd(input string tag, input int x0, input int x1, input int y0, input int y1);
        int base, e0;
        base = wr_q.size();
        e0   = err_cnt;
        set_cmd(x0, x1, y0, y1, 16'hFFFF);
        step(0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0);
        chk({tag, "_busy"}, bus.FILL_BUSY, 0);
        step(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0);
        chk({tag, "_err_pulse"}, err_cnt - e0, 1);
        chk({tag, "_no_writes"}, wr_q.size() - base, 0);
    endtask

    initial begin
        int base, d0, n, mism, rx0, rx1, ry0, ry1;
        int ea[5];
        logic [15:0] ed[5];

        RESET          = 1'b1;
        bus.CPU_WA     = '0;
        bus.CPU_WD     = '0;
        bus.CPU_WE     = 1'b0;
        bus.FILL_START = 1'b0;
        bus.FILL_ABORT = 1'b0;
        set_cmd(0, 0, 0, 0, 16'h0);
        repeat (3) @(negedge CLK_50MHz);
        #1;
        chk("reset_fb_we", bus.FB_WE, 0);
        chk("reset_fb_wa", bus.FB_WA, 0);
        chk("reset_fb_wd", bus.FB_WD, 0);
        chk("reset_busy", bus.FILL_BUSY, 0);
        chk("reset_done", bus.FILL_DONE, 0);
        chk("reset_err", bus.FILL_ERR, 0);
        chk("reset_wait", bus.CPU_WAIT, 0);
        RESET = 1'b0;

        // MCU stores with no fill running: every request lands one cycle later.
        base = wr_q.size();
        exp_cpu.delete();
        n = wait_cnt;
        repeat (6) step(2, 1'b0, 1'b0);
        repeat (2) step(0, 1'b0, 1'b0);
        chk("cpu_only_cnt", wr_q.size() - base, 6);
        mism = 0;
        for (int j = 0; j < exp_cpu.size() && base + j < wr_q.size(); j++)
            if (wr_q[base + j].a !== exp_cpu[j].a || wr_q[base + j].d !== exp_cpu[j].d ||
                wr_q[base + j].c != exp_cpu[j].c) mism++;
        chk("cpu_only_data", mism, 0);
        chk("cpu_only_nowait", wait_cnt - n, 0);
        chk("cpu_only_we_low", bus.FB_WE, 0);
        if (exp_cpu.size() > 0) chk("cpu_only_wa_hold", bus.FB_WA, exp_cpu[exp_cpu.size() - 1].a);

        run_fill("rect_small", 10, 12, 5, 6, 16'h07E0, 0);
        run_fill("full_screen", 0, FB_WIDTH - 1, 0, FB_HEIGHT - 1, 16'hF800, 0);
        run_fill("cpu_held", 3, 7, 2, 4, 16'h1F1F, 2);
        run_fill("single_px", 159, 159, 119, 119, 16'hBEEF, 2);

        bad_cmd("bad_x_order", 20, 10, 0, 0);
        bad_cmd("bad_x1_160", 0, 160, 0, 0);
        bad_cmd("bad_y1_120", 0, 0, 0, 120);

        // Abort after three pixels of (0,0)-(9,0), then restart on the very next cycle.
        base = wr_q.size();
        d0   = done_cnt;
        exp_cpu.delete();
        set_cmd(0, 9, 0, 0, 16'h1234);
        step(0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1);
        set_cmd(5, 6, 100, 100, 16'h5678);
        step(0, 1'b1, 1'b0);
        chk("abort_busy_low", bus.FILL_BUSY, 0);
        step(0, 1'b0, 1'b0);
        chk("abort_restart_busy", bus.FILL_BUSY, 1);
        n = 0;
        while (done_cnt == d0 && n < 20) begin
            step(0, 1'b0, 1'b0);
            n++;
        end
        repeat (2) step(0, 1'b0, 1'b0);
        ea = '{0, 1, 2, 16005, 16006};
        ed = '{16'h1234, 16'h1234, 16'h1234, 16'h5678, 16'h5678};
        chk("abort_wr_cnt", wr_q.size() - base, 5);
        mism = 0;
        for (int j = 0; j < 5 && base + j < wr_q.size(); j++)
            if (int'(wr_q[base + j].a) != ea[j] || wr_q[base + j].d !== ed[j]) mism++;
        chk("abort_wr_seq", mism, 0);
        chk("abort_one_done", done_cnt - d0, 1);

        for (int t = 0; t < 4; t++) begin
            rx0 = $urandom_range(0, FB_WIDTH - 1);
            rx1 = rx0 + $urandom_range(0, 7);
            if (rx1 > FB_WIDTH - 1) rx1 = FB_WIDTH - 1;
            ry0 = $urandom_range(0, FB_HEIGHT - 1);
            ry1 = ry0 + $urandom_range(0, 4);
            if (ry1 > FB_HEIGHT - 1) ry1 = FB_HEIGHT - 1;
            run_fill("rand_rect", rx0, rx1, ry0, ry1, 16'($urandom), 1);
        end

        // Reset in the middle of a full-screen fill.
        base = wr_q.size();
        d0   = done_cnt;
        set_cmd(0, FB_WIDTH - 1, 0, FB_HEIGHT - 1, 16'h001F);
        step(0, 1'b1, 1'b0);
        n = 0;
        while (wr_q.size() - base < 100 && n < 300) begin
            step(0, 1'b0, 1'b0);
            n++;
        end
        chk("rst_mid_progress", wr_q.size() - base, 100);
        #1 RESET = 1'b1;
        #1;
        chk("rst_mid_we", bus.FB_WE, 0);
        chk("rst_mid_wa", bus.FB_WA, 0);
        chk("rst_mid_wd", bus.FB_WD, 0);
        chk("rst_mid_busy", bus.FILL_BUSY, 0);
        chk("rst_mid_done", bus.FILL_DONE, 0);
        repeat (2) @(negedge CLK_50MHz);
        #1 RESET = 1'b0;
        chk("rst_mid_no_done", done_cnt - d0, 0);
        run_fill("post_reset", 40, 43, 60, 61, 16'hABCD, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
